// File: rtl/alu_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Holds the datapath width, op-code encoding and FSM state type.
package alu_pkg;

    localparam int ALU_W = 12;

    localparam logic [3:0] OP_SHR = 4'd0;
    localparam logic [3:0] OP_SHL = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_ADD = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    // Index of the last multiplier bit handled by the shift-add sequencer.
    localparam logic [3:0] MUL_LAST = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 12-bit ALU for ops 0-7 with carry, sign and overflow flags.
// Ops outside 0-7 yield zero result and flags; the caller flags them illegal.
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] z,
    output logic             cout,
    output logic             sign,
    output logic             ov
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        z    = '0;
        cout = 1'b0;
        ov   = 1'b0;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} + {1'b0, ~b} + (ALU_W+1)'(1);
        case (op)
            OP_SHR: z = a >> 1;
            OP_SHL: z = b << 1;
            OP_AND: z = a & b;
            OP_OR:  z = a | b;
            OP_XOR: z = a ^ b;
            OP_NOT: z = ~a;
            OP_ADD: begin
                z    = sum[ALU_W-1:0];
                cout = sum[ALU_W];
                ov   = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            OP_SUB: begin
                z    = diff[ALU_W-1:0];
                cout = diff[ALU_W];
                ov   = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
            end
            default: ;
        endcase
        sign = z[ALU_W-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: round-robin grant, one op in flight, registered response.
// Define ALU_ARBITER_MUL_EN to build the 12-cycle shift-add multiplier for op 8.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ALU_W-1:0] rsp_z,
    output logic             rsp_cout,
    output logic             rsp_sign,
    output logic             rsp_ov,
    output logic             rsp_err
);

    state_t           state;
    logic             ptr;
    logic [ALU_W-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             id_q;

    logic             gnt_any, gnt_id;
    logic [ALU_W-1:0] a_sel, b_sel;
    logic [3:0]       op_sel;

    logic [ALU_W-1:0] core_z;
    logic             core_cout, core_sign, core_ov;

    // On contention the pointer picks the winner; a lone requester always wins.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) gnt_id = ptr;
        else if (req1_valid)          gnt_id = 1'b1;
        a_sel  = gnt_id ? req1_a  : req0_a;
        b_sel  = gnt_id ? req1_b  : req0_b;
        op_sel = gnt_id ? req1_op : req0_op;
    end

    assign req0_ready = !rst && (state == ST_IDLE) && req0_valid && !gnt_id;
    assign req1_ready = !rst && (state == ST_IDLE) && req1_valid &&  gnt_id;

    alu_core u_core (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .z    (core_z),
        .cout (core_cout),
        .sign (core_sign),
        .ov   (core_ov)
    );

`ifdef ALU_ARBITER_MUL_EN
    logic [2*ALU_W-1:0] prod, mcand, prod_next;
    logic [3:0]         cnt;

    assign prod_next = prod + (b_q[0] ? mcand : '0);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_z     <= '0;
            rsp_cout  <= 1'b0;
            rsp_sign  <= 1'b0;
            rsp_ov    <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef ALU_ARBITER_MUL_EN
            cnt       <= '0;
`endif
        end else begin
            // NOTE: operand/op/id registers are loaded before use, so they carry no reset.
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        a_q  <= a_sel;
                        b_q  <= b_sel;
                        op_q <= op_sel;
                        id_q <= gnt_id;
                        if (req0_valid && req1_valid) ptr <= ~gnt_id;
`ifdef ALU_ARBITER_MUL_EN
                        prod  <= '0;
                        mcand <= {{ALU_W{1'b0}}, a_sel};
                        cnt   <= '0;
                        state <= (op_sel == OP_MUL) ? ST_MUL : ST_EXEC;
`else
                        state <= ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    if (op_q > OP_SUB) begin
                        rsp_z    <= '0;
                        rsp_cout <= 1'b0;
                        rsp_sign <= 1'b0;
                        rsp_ov   <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_z    <= core_z;
                        rsp_cout <= core_cout;
                        rsp_sign <= core_sign;
                        rsp_ov   <= core_ov;
                        rsp_err  <= 1'b0;
                    end
                    state <= ST_RESP;
                end
`ifdef ALU_ARBITER_MUL_EN
                ST_MUL: begin
                    if (cnt == MUL_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_z     <= prod_next[ALU_W-1:0];
                        rsp_cout  <= |prod_next[2*ALU_W-1:ALU_W];
                        rsp_ov    <= |prod_next[2*ALU_W-1:ALU_W];
                        rsp_sign  <= prod_next[ALU_W-1];
                        rsp_err   <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_RESP;
                    end else begin
                        prod  <= prod_next;
                        mcand <= mcand << 1;
                        b_q   <= b_q >> 1;
                        cnt   <= cnt + 4'd1;
                    end
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model compared
// every cycle, directed literal cases, then randomized traffic with occasional reset.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [ALU_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_op, req1_op;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [ALU_W-1:0] rsp_z;
    logic             rsp_cout, rsp_sign, rsp_ov, rsp_err;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_cout(rsp_cout), .rsp_sign(rsp_sign),
        .rsp_ov(rsp_ov), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] z;
        logic        cout;
        logic        sign;
        logic        ov;
        logic        err;
    } exp_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int to_signed12(input int v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    // Result of one operation computed from plain integer arithmetic.
    function automatic exp_t ref_model(input int a, input int b, input int op);
        exp_t r;
        int   s, d;
        r = '0;
        case (op)
            0: r.z = 12'(a / 2);
            1: r.z = 12'((b * 2) % 4096);
            2: r.z = 12'(a & b);
            3: r.z = 12'(a | b);
            4: r.z = 12'(a ^ b);
            5: r.z = 12'(4095 - a);
            6: begin
                s = a + b;
                r.z = 12'(s % 4096);
                r.cout = (s >= 4096);
                d = to_signed12(a) + to_signed12(b);
                r.ov = (d > 2047) || (d < -2048);
            end
            7: begin
                r.z = 12'((a - b + 4096) % 4096);
                r.cout = (a >= b);
                d = to_signed12(a) - to_signed12(b);
                r.ov = (d > 2047) || (d < -2048);
            end
            8: begin
`ifdef ALU_ARBITER_MUL_EN
                s = a * b;
                r.z = 12'(s % 4096);
                r.cout = (s >= 4096);
                r.ov = (s >= 4096);
`else
                r.err = 1'b1;
`endif
            end
            default: r.err = 1'b1;
        endcase
        r.sign = !r.err && (r.z >= 12'd2048);
        return r;
    endfunction

    function automatic int op_cycles(input int op);
`ifdef ALU_ARBITER_MUL_EN
        if (op == 8) return 12;
`endif
        return 1;
    endfunction

    // Transaction-level model: busy from accept until the response handshake.
    bit   m_busy = 0, m_rv = 0, m_ptr = 0, m_id = 0, m_pend_id = 0;
    int   m_wait = 0;
    exp_t m_resp = '0, m_pend = '0;

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_busy = 0; m_rv = 0; m_ptr = 0; m_id = 0; m_resp = '0;
        end else if (m_rv) begin
            if (rsp_ready) begin m_rv = 0; m_busy = 0; end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin m_rv = 1; m_resp = m_pend; m_id = m_pend_id; end
        end else if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? int'(m_ptr) : (req1_valid ? 1 : 0);
            if (req0_valid && req1_valid) m_ptr = !m_ptr;
            if (g == 0) m_pend = ref_model(int'(req0_a), int'(req0_b), int'(req0_op));
            else        m_pend = ref_model(int'(req1_a), int'(req1_b), int'(req1_op));
            m_wait    = op_cycles(g == 0 ? int'(req0_op) : int'(req1_op));
            m_pend_id = (g == 1);
            m_busy    = 1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit e_r0, e_r1;
        if (cmp_en) begin
            e_r0 = !rst && !m_busy && req0_valid && !(req1_valid && m_ptr);
            e_r1 = !rst && !m_busy && req1_valid && !(req0_valid && !m_ptr);
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            check("rsp_valid", rsp_valid, m_rv);
            if (m_rv)
                check("rsp_fields", {rsp_id, rsp_z, rsp_cout, rsp_sign, rsp_ov, rsp_err},
                      {m_id, m_resp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (req0_ready) begin g = 0; break; end
            if (req1_ready) begin g = 1; break; end
        end
    endtask

    task automatic wait_rsp(input int acc, output int lat);
        lat = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = cyc - acc; break; end
        end
    endtask

    // Issues one request on a single port; returns at the first rsp_valid negedge.
    task automatic do_op(input int id, input logic [11:0] a, input logic [11:0] b,
                         input logic [3:0] op, output int lat);
        int g, acc;
        rsp_ready = 1'b0;
        req0_valid = (id == 0); req0_a = a; req0_b = b; req0_op = op;
        req1_valid = (id == 1); req1_a = a; req1_b = b; req1_op = op;
        wait_grant(g);
        check("grant_id", g, id);
        acc = cyc;
        @(posedge clk); #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(acc, lat);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string name, input logic [11:0] z, input logic c,
                             input logic s, input logic o, input logic e);
        check({name, "_z"}, rsp_z, z);
        check({name, "_flags"}, {rsp_cout, rsp_sign, rsp_ov, rsp_err}, {c, s, o, e});
    endtask

    function automatic logic [11:0] rnd12();
        case ($urandom_range(0, 5))
            0: return 12'h000;
            1: return 12'h7FF;
            2: return 12'h800;
            3: return 12'hFFF;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g, seen;
        int gl[4];
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 12'h123; req0_b = 12'h456; req0_op = 4'd6;
        req1_valid = 1'b1; req1_a = 12'h321; req1_b = 12'h654; req1_op = 4'd7;
        tick();
        cmp_en = 1'b1;

        // Reset state with both requesters valid.
        @(negedge clk);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_sign, rsp_ov, rsp_err}, '0);
        @(posedge clk); #2;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        do_op(0, 12'h7FF, 12'h001, 4'd6, lat);
        check("add_lat", lat, 2);
        check_rsp("add_ovf", 12'h800, 1'b0, 1'b1, 1'b1, 1'b0);
        release_rsp();

        do_op(1, 12'h005, 12'h007, 4'd7, lat);
        check("sub_lat", lat, 2);
        check("sub_id", rsp_id, 1'b1);
        check_rsp("sub_neg", 12'hFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        release_rsp();

`ifdef ALU_ARBITER_MUL_EN
        do_op(0, 12'h010, 12'h020, 4'd8, lat);
        check("mul_lat", lat, 13);
        check_rsp("mul_small", 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        release_rsp();
        do_op(1, 12'h100, 12'h100, 4'd8, lat);
        check("mul_lat2", lat, 13);
        check_rsp("mul_big", 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        release_rsp();
`else
        do_op(0, 12'h010, 12'h020, 4'd8, lat);
        check("mul_off_lat", lat, 2);
        check_rsp("mul_off", 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        release_rsp();
`endif

        do_op(1, 12'hABC, 12'h123, 4'd13, lat);
        check("illegal_lat", lat, 2);
        check_rsp("illegal", 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        release_rsp();

        do_op(0, 12'h801, 12'h002, 4'd0, lat);
        check_rsp("shr", 12'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        release_rsp();

        // Both requesters held valid right after reset: alternating grants.
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 12'h001; req0_b = 12'h002; req0_op = 4'd6;
        req1_valid = 1'b1; req1_a = 12'h0F0; req1_b = 12'h0FF; req1_op = 4'd2;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 64 && seen < 4; c++) begin
            @(negedge clk);
            if (req0_ready) begin gl[seen] = 0; seen++; end
            else if (req1_ready) begin gl[seen] = 1; seen++; end
        end
        rsp_ready = 1'b0;
        check("rr_count", seen, 4);
        check("rr_order", {gl[0][0], gl[1][0], gl[2][0], gl[3][0]}, 4'b0101);
        wait_rsp(cyc, lat);
        check("hold_seen", lat >= 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_nogrant", {req0_ready, req1_ready}, 2'b00);
            check("hold_z", rsp_z, 12'h0F0);
        end
        rsp_ready = 1'b1;
        wait_grant(g);
        check("rr_next", g, 0);
        @(posedge clk); #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();

        // Reset in the 6th cycle after accepting op 8 discards it and clears the pointer.
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 12'h003; req0_b = 12'h005; req0_op = 4'd8;
        req1_valid = 1'b1; req1_a = 12'h00F; req1_b = 12'h0F0; req1_op = 4'd3;
        tick();
        rst = 1'b0;
        wait_grant(g);
        check("mulrst_grant", g, 0);
        @(posedge clk); #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mulrst_norsp", seen, 0);
        @(posedge clk); #2;
        req0_valid = 1'b1; req0_a = 12'hF0F; req0_b = 12'h0FF; req0_op = 4'd4;
        req1_valid = 1'b1; req1_a = 12'h111; req1_b = 12'h222; req1_op = 4'd2;
        wait_grant(g);
        check("ptr_after_rst", g, 0);
        lat = cyc;
        @(posedge clk); #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat, lat);
        check("post_rst_lat", lat, 2);
        check("post_rst_id", rsp_id, 1'b0);
        check_rsp("post_rst", 12'hFF0, 1'b0, 1'b1, 1'b0, 1'b0);
        release_rsp();

        // Randomized traffic; the model and compare process do all the checking here.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            rsp_ready  = ($urandom_range(0, 9) < 7);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = rnd12(); req0_b = rnd12();
            req1_a = rnd12(); req1_b = rnd12();
            req0_op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            req1_op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            tick();
        end

        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: reqN_valid  in  1  request N present (N=0,1).
REQ-004 SHALL have ports: reqN_ready  out  1  request N accepted this cycle when reqN_valid also high.
REQ-005 SHALL have ports: reqN_a, reqN_b  in  12 each  operands; reqN_op  in  4  operation code.
REQ-006 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  requester index.
REQ-007 SHALL have ports: rsp_z  out  12  result; rsp_cout, rsp_sign, rsp_ov, rsp_err  out  1 each  flags.

Function
REQ-008 SHALL implement op codes 0: A>>1, 1: B<<1, 2: A&B, 3: A|B, 4: A^B, 5: ~A, 6: A+B, 7: A-B, 8: MUL, 9-15: illegal.
REQ-009 SHALL compute 12-bit results modulo 2^12.
REQ-010 SHALL set cout to bit 12 of {0,A}+{0,B} for op 6, and to bit 12 of {0,A}+{0,~B}+1 for op 7.
REQ-011 SHALL set ov to two's-complement overflow for ops 6 and 7; cout=ov=0 for ops 0-5.
REQ-012 SHALL set rsp_sign=rsp_z[11] for every legal op.
REQ-013 SHALL run FSM states IDLE, EXEC, MUL, RESP; reqN_ready SHALL be high only in IDLE, and only for the granted requester.
REQ-014 SHALL grant the sole valid requester when one is valid; when both are valid, SHALL grant the requester named by a priority pointer, then set the pointer to the other requester.
REQ-015 SHALL register operands, op and id on acceptance; IDLE->EXEC for ops 0-7 and illegal ops, IDLE->MUL for op 8.
REQ-016 SHALL compute and register the result in EXEC, then go to RESP; first rsp_valid cycle is the 2nd cycle after the accept cycle.
REQ-017 SHALL compute MUL as unsigned shift-add, one multiplier bit per cycle for 12 cycles, then go to RESP; first rsp_valid cycle is the 13th cycle after the accept cycle.
REQ-018 SHALL make MUL rsp_z the low 12 product bits, and set cout=ov=1 if any of bits 23:12 are nonzero.
REQ-019 SHALL hold rsp_* stable in RESP while rsp_ready=0; on rsp_valid&rsp_ready SHALL go RESP->IDLE, so at most one request is in flight (minimum 3 cycles per op).
REQ-020 SHALL complete an illegal op with rsp_err=1, rsp_z=0, all other flags 0, and EXEC latency; rsp_err=0 otherwise.
REQ-021 SHALL leave reqN_valid independent of reqN_ready; a request not accepted SHALL remain pending with no side effect.

Reset
REQ-022 SHALL, on rst, go to IDLE, set rsp_valid=0, rsp_z=0, all flags 0, rsp_id=0, priority pointer=0, and clear the multiply counter.
REQ-023 SHALL let rst dominate every state: an in-flight EXEC, MUL or RESP operation is discarded with no response.
REQ-024 SHALL hold reqN_ready low in the reset cycle.

Configuration
REQ-025 SHALL compile the multiply sequencer (MUL state, counter, product register) only when macro ALU_ARBITER_MUL_EN is defined.
REQ-026 SHALL, without ALU_ARBITER_MUL_EN, treat op 8 as illegal per REQ-020; ops 0-7 behave identically in both builds.

Structure
REQ-027 SHALL place op-code constants, the 12-bit width constant and the FSM state typedef in shared package alu_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module alu_core (ops 0-7 plus cout/sign/ov), shared by both requesters.

Verification
REQ-029 SHALL verify op 6, A=0x7FF, B=0x001 -> rsp_z=0x800, sign=1, ov=1, cout=0, rsp_valid on 2nd cycle after accept.
REQ-030 SHALL verify op 7, A=0x005, B=0x007 -> rsp_z=0xFFE, sign=1, cout=0, ov=0.
REQ-031 SHALL verify op 8 with MUL_EN: 0x010*0x020 -> rsp_z=0x200, cout=ov=0, latency 13; 0x100*0x100 -> rsp_z=0x000, cout=ov=1; without MUL_EN -> rsp_err=1, rsp_z=0.
REQ-032 SHALL verify both requesters continuously valid after reset -> grants in order id 0,1,0,1; rsp_ready held low 5 cycles -> outputs stable, no new grant.
REQ-033 SHALL verify rst asserted in cycle 6 of a MUL -> no rsp_valid, next request completes correctly with pointer=0.
